// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmit path:
// state encoding, 50 MHz timing defaults and frame helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RTS      = 3'd2,
        ST_WAIT_DEV = 3'd3,
        ST_TX       = 3'd4,
        ST_WAIT_ACK = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERROR    = 3'd7
    } tx_state_t;

    localparam int PS2_CLK_INHIBIT_CYCLES = 5000;
    localparam int PS2_RTS_HOLD_CYCLES    = 16;
    localparam int PS2_START_TIMEOUT      = 750000;
    localparam int PS2_XFER_TIMEOUT       = 100000;
    localparam int PS2_FRAME_BITS         = 11;
    localparam int PS2_TIMER_W            = 20;

    typedef logic [PS2_TIMER_W-1:0] timer_t;

    // Odd parity sits above the data byte so the shifter emits it ninth.
    function automatic logic [8:0] frame_payload(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_command_out.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame
// and ACK check, driving the open-drain PS/2 lines low or releasing them.
module ps2_command_out
    import ps2_pkg::*;
#(
    parameter int CLK_INHIBIT_CYCLES = PS2_CLK_INHIBIT_CYCLES,
    parameter int RTS_HOLD_CYCLES    = PS2_RTS_HOLD_CYCLES,
    parameter int START_TIMEOUT      = PS2_START_TIMEOUT,
    parameter int XFER_TIMEOUT       = PS2_XFER_TIMEOUT
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam timer_t     INHIBIT_LAST = timer_t'(CLK_INHIBIT_CYCLES - 1);
    localparam timer_t     RTS_LAST     = timer_t'(RTS_HOLD_CYCLES - 1);
    localparam timer_t     START_LAST   = timer_t'(START_TIMEOUT - 1);
    localparam timer_t     XFER_LAST    = timer_t'(XFER_TIMEOUT - 1);
    // bit_cnt holds this value when the negedge that releases the stop bit arrives.
    localparam logic [3:0] STOP_NEG_CNT = 4'(PS2_FRAME_BITS - 2);

    tx_state_t  state;
    tx_state_t  next_state;
    timer_t     phase_cnt;
    timer_t     xfer_cnt;
    logic [3:0] bit_cnt;
    logic [8:0] shift;
    logic       data_low;
    logic       ack_seen;
    logic       clk_oe;
    logic       dat_oe;
    logic       bit_edge;

    assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Timeouts take priority over a strobe arriving in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (send_command) next_state = ST_INHIBIT;
            ST_INHIBIT:  if (phase_cnt == INHIBIT_LAST) next_state = ST_RTS;
            ST_RTS:      if (phase_cnt == RTS_LAST) next_state = ST_WAIT_DEV;
            ST_WAIT_DEV: begin
                if (phase_cnt == START_LAST)  next_state = ST_ERROR;
                else if (ps2_clk_negedge)     next_state = ST_TX;
            end
            ST_TX: begin
                if (xfer_cnt == XFER_LAST)    next_state = ST_ERROR;
                else if (ps2_clk_negedge && bit_cnt == STOP_NEG_CNT)
                                              next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (xfer_cnt == XFER_LAST) begin
                    next_state = ST_ERROR;
                end else if (ps2_clk_posedge && !ps2_clk_negedge) begin
                    if (!ps2_data)     next_state = ST_DONE;
                    else if (ack_seen) next_state = ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: if (!send_command) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    assign bit_edge = (state == ST_WAIT_DEV || state == ST_TX) && ps2_clk_negedge
                      && next_state != ST_ERROR;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt <= '0;
            xfer_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data_low  <= 1'b0;
            ack_seen  <= 1'b0;
        end else begin
            if (state != next_state)  phase_cnt <= '0;
            else if (phase_cnt != '1) phase_cnt <= phase_cnt + 1'b1;

            if (state == ST_WAIT_DEV) xfer_cnt <= '0;
            else if ((state == ST_TX || state == ST_WAIT_ACK) && xfer_cnt != '1)
                xfer_cnt <= xfer_cnt + 1'b1;

            if (state == ST_IDLE && send_command) begin
                shift    <= frame_payload(the_command);
                bit_cnt  <= '0;
                data_low <= 1'b1;
                ack_seen <= 1'b0;
            end else if (bit_edge) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (state == ST_TX && bit_cnt == STOP_NEG_CNT) begin
                    data_low <= 1'b0;
                end else begin
                    data_low <= ~shift[0];
                    shift    <= {1'b0, shift[8:1]};
                end
            end else if (state == ST_WAIT_ACK && ps2_clk_negedge) begin
                ack_seen <= 1'b1;
            end
        end
    end

    // Line enables and status flags are decoded from the registered state.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_oe                        <= 1'b0;
            dat_oe                        <= 1'b0;
            command_was_sent              <= 1'b0;
            error_communication_timed_out <= 1'b0;
        end else begin
            clk_oe <= state == ST_INHIBIT || state == ST_RTS;
            dat_oe <= state == ST_RTS ||
                      ((state == ST_WAIT_DEV || state == ST_TX) && data_low);
            command_was_sent              <= state == ST_DONE;
            error_communication_timed_out <= state == ST_ERROR;
        end
    end

endmodule

// File: tb/tb_ps2_command_out.sv
// Self-checking bench for ps2_command_out: a PS/2 device model clocks frames
// and every sampled wire bit and transfer result is checked against a scoreboard.
module tb_ps2_command_out;

    localparam int INHIBIT  = 50;
    localparam int RTS      = 16;
    localparam int START_TO = 2000;
    localparam int XFER_TO  = 1500;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [7:0] the_command;
    logic       send_command;
    logic       pos_strobe;
    logic       neg_strobe;
    logic       dev_low;
    logic       ps2_data;
    logic       done;
    logic       err;
    wire        clk_line;
    wire        dat_line;

    pullup (clk_line);
    pullup (dat_line);
    assign ps2_data = dev_low ? 1'b0 : dat_line;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    bit exp_q[$];
    bit seen_q[$];
    bit exp_res_q[$];

    ps2_command_out #(
        .CLK_INHIBIT_CYCLES(INHIBIT),
        .RTS_HOLD_CYCLES(RTS),
        .START_TIMEOUT(START_TO),
        .XFER_TIMEOUT(XFER_TO)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n(reset_n),
        .the_command(the_command),
        .send_command(send_command),
        .ps2_clk_posedge(pos_strobe),
        .ps2_clk_negedge(neg_strobe),
        .ps2_data(ps2_data),
        .PS2_CLK(clk_line),
        .PS2_DAT(dat_line),
        .command_was_sent(done),
        .error_communication_timed_out(err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (done) done_pulses <= done_pulses + 1;
        if (err)  err_pulses  <= err_pulses + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected wire sequence: start 0, data LSB first, odd parity, stop 1.
    task automatic push_expected(input logic [7:0] c);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(c[i]);
        exp_q.push_back(($countones(c) % 2) == 0);
        exp_q.push_back(1'b1);
    endtask

    task automatic wait_clk_release(output int low_only, output int both_low, output bit ok);
        int guard;
        low_only = 0;
        both_low = 0;
        ok = 1'b1;
        guard = 0;
        while (clk_line !== 1'b0 && guard < 200) begin
            @(negedge CLOCK_50);
            guard++;
        end
        if (clk_line !== 1'b0) ok = 1'b0;
        guard = 0;
        while (clk_line === 1'b0 && guard < 500) begin
            if (dat_line === 1'b0) both_low++;
            else                   low_only++;
            @(negedge CLOCK_50);
            guard++;
        end
        if (clk_line === 1'b0) ok = 1'b0;
    endtask

    // Device model: n clock pulses, sampling the host bit before each rising edge.
    task automatic dev_clock(input int n, input bit ack, output int t_first);
        t_first = 0;
        seen_q.push_back(dat_line);
        for (int k = 1; k <= n; k++) begin
            @(negedge CLOCK_50);
            neg_strobe = 1'b1;
            @(negedge CLOCK_50);
            neg_strobe = 1'b0;
            if (k == 1) t_first = cyc;
            if (k == 11 && ack) dev_low = 1'b1;
            repeat (4) @(negedge CLOCK_50);
            if (k <= 10) seen_q.push_back(dat_line);
            pos_strobe = 1'b1;
            @(negedge CLOCK_50);
            pos_strobe = 1'b0;
            repeat (4) @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        send_command = 1'b0;
        the_command = 8'h00;
        pos_strobe = 1'b0;
        neg_strobe = 1'b0;
        dev_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks += 4;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done actual=%b required=0", done); end
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err actual=%b required=0", err); end
        if (clk_line !== 1'b1) begin failures++; $display("[TB] FAIL reset_clk actual=%b required=1", clk_line); end
        if (dat_line !== 1'b1) begin failures++; $display("[TB] FAIL reset_dat actual=%b required=1", dat_line); end
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        the_command = 8'hA5;
        send_command = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        checks++;
        if (clk_line !== 1'b0) begin failures++; $display("[TB] FAIL inhibit_clk actual=%b required=0", clk_line); end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (clk_line !== 1'b1) begin failures++; $display("[TB] FAIL async_reset_clk actual=%b required=1", clk_line); end
        @(negedge CLOCK_50);
        send_command = 1'b0;
        reset_n = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic test_command_ed();
        int lo, both, t0, snap_d, snap_e;
        bit ok, exp_done;
        push_expected(8'hED);
        exp_res_q.push_back(1'b1);
        snap_d = done_pulses;
        snap_e = err_pulses;
        @(negedge CLOCK_50);
        the_command = 8'hED;
        send_command = 1'b1;
        wait_clk_release(lo, both, ok);
        the_command = 8'h00;
        checks += 3;
        if (!ok) begin failures++; $display("[TB] FAIL ed_release actual=stuck required=released"); end
        if (lo != INHIBIT) begin failures++; $display("[TB] FAIL ed_inhibit actual=%0d required=%0d", lo, INHIBIT); end
        if (both != RTS) begin failures++; $display("[TB] FAIL ed_rts actual=%0d required=%0d", both, RTS); end
        dev_clock(11, 1'b1, t0);
        checks++;
        if (seen_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL ed_bitcount actual=%0d required=%0d", seen_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && seen_q.size() > 0; i++) begin
            bit e, s;
            e = exp_q.pop_front();
            s = seen_q.pop_front();
            checks++;
            if (s !== e) begin failures++; $display("[TB] FAIL ed_bit%0d actual=%b required=%b", i, s, e); end
        end
        exp_q.delete();
        seen_q.delete();
        exp_done = exp_res_q.pop_front();
        checks += 2;
        if (done !== exp_done) begin failures++; $display("[TB] FAIL ed_sent actual=%b required=%b", done, exp_done); end
        if ((err_pulses > snap_e) || err) begin failures++; $display("[TB] FAIL ed_err actual=1 required=0"); end
        send_command = 1'b0;
        dev_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL ed_idle_done actual=%b required=0", done); end
        if (dat_line !== 1'b1 || clk_line !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ed_idle_lines actual=%b%b required=11", clk_line, dat_line);
        end
        if (done_pulses == snap_d) $display("[TB] note: no done samples recorded");
    endtask

    task automatic test_parity();
        logic [7:0] cmds [2];
        int lo, both, t0, snap_d;
        bit ok, exp_done;
        cmds[0] = 8'h00;
        cmds[1] = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            push_expected(cmds[c]);
            exp_res_q.push_back(1'b1);
            snap_d = done_pulses;
            @(negedge CLOCK_50);
            the_command = cmds[c];
            send_command = 1'b1;
            wait_clk_release(lo, both, ok);
            if (c == 1) send_command = 1'b0;
            dev_clock(11, 1'b1, t0);
            repeat (2) @(negedge CLOCK_50);
            checks++;
            if (seen_q.size() != exp_q.size()) begin
                failures++;
                $display("[TB] FAIL par%0d_bitcount actual=%0d required=%0d", c, seen_q.size(), exp_q.size());
            end
            for (int i = 0; exp_q.size() > 0 && seen_q.size() > 0; i++) begin
                bit e, s;
                e = exp_q.pop_front();
                s = seen_q.pop_front();
                checks++;
                if (s !== e) begin failures++; $display("[TB] FAIL par%0d_bit%0d actual=%b required=%b", c, i, s, e); end
            end
            exp_q.delete();
            seen_q.delete();
            exp_done = exp_res_q.pop_front();
            checks++;
            if ((done_pulses > snap_d) !== exp_done) begin
                failures++;
                $display("[TB] FAIL par%0d_sent actual=%b required=%b", c, done_pulses > snap_d, exp_done);
            end
            if (c == 1) begin
                checks++;
                if (done_pulses - snap_d != 1) begin
                    failures++;
                    $display("[TB] FAIL drop_send_pulse actual=%0d required=1", done_pulses - snap_d);
                end
            end
            send_command = 1'b0;
            dev_low = 1'b0;
            repeat (3) @(negedge CLOCK_50);
        end
    endtask

    task automatic test_start_timeout();
        int lo, both, n, snap_d;
        bit ok, exp_done;
        exp_res_q.push_back(1'b0);
        snap_d = done_pulses;
        @(negedge CLOCK_50);
        the_command = 8'h12;
        send_command = 1'b1;
        wait_clk_release(lo, both, ok);
        n = 0;
        while (err !== 1'b1 && n < START_TO + 1000) begin
            @(negedge CLOCK_50);
            n++;
        end
        exp_done = exp_res_q.pop_front();
        checks += 2;
        if (n != START_TO) begin failures++; $display("[TB] FAIL start_timeout_cycles actual=%0d required=%0d", n, START_TO); end
        if (err !== !exp_done || (done_pulses > snap_d) !== exp_done) begin
            failures++;
            $display("[TB] FAIL start_timeout_result actual=err%b required=err%b", err, !exp_done);
        end
        seen_q.delete();
        send_command = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL start_timeout_clear actual=%b required=0", err); end
    endtask

    task automatic test_xfer_timeout();
        int lo, both, t0, n, snap_d;
        bit ok, exp_done;
        exp_res_q.push_back(1'b0);
        snap_d = done_pulses;
        @(negedge CLOCK_50);
        the_command = 8'h77;
        send_command = 1'b1;
        wait_clk_release(lo, both, ok);
        dev_clock(5, 1'b0, t0);
        n = 0;
        while (err !== 1'b1 && n < XFER_TO + 1000) begin
            @(negedge CLOCK_50);
            n++;
        end
        exp_done = exp_res_q.pop_front();
        checks += 2;
        // The error flag follows the ERROR state by one clock.
        if (cyc - t0 != XFER_TO + 1) begin
            failures++;
            $display("[TB] FAIL xfer_timeout_cycles actual=%0d required=%0d", cyc - t0, XFER_TO + 1);
        end
        if (err !== !exp_done || (done_pulses > snap_d) !== exp_done) begin
            failures++;
            $display("[TB] FAIL xfer_timeout_result actual=err%b required=err%b", err, !exp_done);
        end
        seen_q.delete();
        send_command = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks += 2;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL xfer_clear_err actual=%b required=0", err); end
        if (clk_line !== 1'b1 || dat_line !== 1'b1) begin
            failures++;
            $display("[TB] FAIL xfer_idle_lines actual=%b%b required=11", clk_line, dat_line);
        end
    endtask

    task automatic test_no_ack();
        int lo, both, t0, n, snap_d;
        bit ok, exp_done;
        exp_res_q.push_back(1'b0);
        snap_d = done_pulses;
        @(negedge CLOCK_50);
        the_command = 8'h5A;
        send_command = 1'b1;
        wait_clk_release(lo, both, ok);
        dev_clock(11, 1'b0, t0);
        n = 0;
        while (err !== 1'b1 && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        exp_done = exp_res_q.pop_front();
        checks += 2;
        if (err !== !exp_done) begin failures++; $display("[TB] FAIL no_ack_err actual=%b required=%b", err, !exp_done); end
        if ((done_pulses > snap_d) !== exp_done) begin
            failures++;
            $display("[TB] FAIL no_ack_sent actual=%0d required=0", done_pulses - snap_d);
        end
        seen_q.delete();
        send_command = 1'b0;
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic test_reset_mid_tx();
        int lo, both, t0;
        bit ok, exp_done;
        @(negedge CLOCK_50);
        the_command = 8'hED;
        send_command = 1'b1;
        wait_clk_release(lo, both, ok);
        dev_clock(5, 1'b0, t0);
        checks++;
        if (dat_line !== 1'b0) begin failures++; $display("[TB] FAIL mid_tx_bit4 actual=%b required=0", dat_line); end
        #2 reset_n = 1'b0;
        #1;
        checks += 3;
        if (dat_line !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_dat actual=%b required=1", dat_line); end
        if (clk_line !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_clk actual=%b required=1", clk_line); end
        if (done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_flags actual=%b%b required=00", done, err);
        end
        seen_q.delete();
        send_command = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        push_expected(8'h3C);
        exp_res_q.push_back(1'b1);
        @(negedge CLOCK_50);
        the_command = 8'h3C;
        send_command = 1'b1;
        wait_clk_release(lo, both, ok);
        dev_clock(11, 1'b1, t0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            bit e, s;
            e = exp_q.pop_front();
            s = (seen_q.size() > 0) ? seen_q.pop_front() : 1'bx;
            checks++;
            if (s !== e) begin failures++; $display("[TB] FAIL resend_bit%0d actual=%b required=%b", i, s, e); end
        end
        seen_q.delete();
        exp_done = exp_res_q.pop_front();
        checks++;
        if (done !== exp_done) begin failures++; $display("[TB] FAIL resend_sent actual=%b required=%b", done, exp_done); end
        send_command = 1'b0;
        dev_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        test_reset();
        test_command_ed();
        test_parity();
        test_start_timeout();
        test_xfer_timeout();
        test_no_ack();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
